// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute core: opcode/funct values and
// the decode select enums consumed by the top and the ALU.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL     = 6'h00;
    localparam logic [5:0] F_SRL     = 6'h02;
    localparam logic [5:0] F_SRA     = 6'h03;
    localparam logic [5:0] F_SLLV    = 6'h04;
    localparam logic [5:0] F_SRLV    = 6'h06;
    localparam logic [5:0] F_SRAV    = 6'h07;
    localparam logic [5:0] F_JR      = 6'h08;
    localparam logic [5:0] F_SYSCALL = 6'h0C;
    localparam logic [5:0] F_ADD     = 6'h20;
    localparam logic [5:0] F_ADDU    = 6'h21;
    localparam logic [5:0] F_SUB     = 6'h22;
    localparam logic [5:0] F_SUBU    = 6'h23;
    localparam logic [5:0] F_AND     = 6'h24;
    localparam logic [5:0] F_OR      = 6'h25;
    localparam logic [5:0] F_XOR     = 6'h26;
    localparam logic [5:0] F_NOR     = 6'h27;
    localparam logic [5:0] F_SLT     = 6'h2A;
    localparam logic [5:0] F_SLTU    = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_t;

    typedef enum logic [1:0] {WB_ALU, WB_DM, WB_PC1} wb_sel_t;
    typedef enum logic [1:0] {PC_INC, PC_BRANCH, PC_JIMM, PC_JREG} pc_sel_t;
    typedef enum logic {EXT_ZERO, EXT_SIGN} imm_ext_t;

endpackage

// File: rtl/mips_exec_core_if.sv
// Bus between the execute core and its ROM / register file / data RAM.
interface mips_exec_core_if;
    logic [31:0] ins, rs_data, rt_data, v0_data, a0_data, dm_rdata;
    logic [31:0] pc, wr_data, dm_wdata, alu_result, display;
    logic [4:0]  rs_num, rt_num, wr_num;
    logic [7:0]  dm_addr;
    logic        wr_en, dm_cs, dm_rd, halt;

    modport master (
        input  ins, rs_data, rt_data, v0_data, a0_data, dm_rdata,
        output pc, rs_num, rt_num, wr_num, wr_data, wr_en, dm_addr,
               dm_wdata, dm_cs, dm_rd, alu_result, display, halt
    );
    modport slave (
        output ins, rs_data, rt_data, v0_data, a0_data, dm_rdata,
        input  pc, rs_num, rt_num, wr_num, wr_data, wr_en, dm_addr,
               dm_wdata, dm_cs, dm_rd, alu_result, display, halt
    );
endinterface

// File: rtl/exec_alu.sv
// Combinational ALU; zero flag feeds the beq/bne decision.
module exec_alu
    import mips_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_SLL:  result = a << b[4:0];
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_LUI:  result = {b[15:0], 16'h0};
            default:  result = '0;
        endcase
        zero = (result == '0);
    end
endmodule

// File: rtl/mips_exec_core.sv
// Single-cycle MIPS execute/sequencing: decode, ALU, write-back select,
// next-PC and syscall halt/display.
module mips_exec_core
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_CODE = 32'd10
) (
    input  logic clk,
    input  logic clr,
    mips_exec_core_if.master bus
);
    logic [31:0] pc_q, display_q, imm, alu_a, alu_b, alu_res, pc1, next_pc;
    logic        halt_q, alu_zero, use_imm, we, cs, rd, is_syscall, taken;
    logic [4:0]  dst;
    logic [5:0]  opcode, funct;
    alu_op_t     alu_op;
    wb_sel_t     wb_sel;
    pc_sel_t     pc_sel;
    imm_ext_t    ext;

    assign opcode = bus.ins[31:26];
    assign funct  = bus.ins[5:0];

    always_comb begin
        alu_op = ALU_ADD;  alu_a = bus.rs_data;  alu_b = bus.rt_data;
        ext = EXT_SIGN;    use_imm = 1'b0;       wb_sel = WB_ALU;
        pc_sel = PC_INC;   dst = bus.ins[20:16];
        we = 1'b0;  cs = 1'b0;  rd = 1'b0;  is_syscall = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dst = bus.ins[15:11];
                we  = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: alu_op = ALU_ADD;
                    F_SUB, F_SUBU: alu_op = ALU_SUB;
                    F_AND:  alu_op = ALU_AND;
                    F_OR:   alu_op = ALU_OR;
                    F_XOR:  alu_op = ALU_XOR;
                    F_NOR:  alu_op = ALU_NOR;
                    F_SLT:  alu_op = ALU_SLT;
                    F_SLTU: alu_op = ALU_SLTU;
                    F_SLL:  begin alu_op = ALU_SLL; alu_a = bus.rt_data; alu_b = {27'b0, bus.ins[10:6]}; end
                    F_SRL:  begin alu_op = ALU_SRL; alu_a = bus.rt_data; alu_b = {27'b0, bus.ins[10:6]}; end
                    F_SRA:  begin alu_op = ALU_SRA; alu_a = bus.rt_data; alu_b = {27'b0, bus.ins[10:6]}; end
                    F_SLLV: begin alu_op = ALU_SLL; alu_a = bus.rt_data; alu_b = bus.rs_data; end
                    F_SRLV: begin alu_op = ALU_SRL; alu_a = bus.rt_data; alu_b = bus.rs_data; end
                    F_SRAV: begin alu_op = ALU_SRA; alu_a = bus.rt_data; alu_b = bus.rs_data; end
                    F_JR:      begin we = 1'b0; pc_sel = PC_JREG; end
                    F_SYSCALL: begin we = 1'b0; is_syscall = 1'b1; end
                    default:   we = 1'b0;
                endcase
            end
            OP_J:   pc_sel = PC_JIMM;
            OP_JAL: begin pc_sel = PC_JIMM; dst = 5'd31; we = 1'b1; wb_sel = WB_PC1; end
            // Branches subtract rs-rt so the ALU zero flag is the equality test
            OP_BEQ, OP_BNE: begin alu_op = ALU_SUB; pc_sel = PC_BRANCH; end
            OP_ADDI, OP_ADDIU: begin use_imm = 1'b1; we = 1'b1; end
            OP_SLTI:  begin use_imm = 1'b1; we = 1'b1; alu_op = ALU_SLT; end
            OP_SLTIU: begin use_imm = 1'b1; we = 1'b1; alu_op = ALU_SLTU; end
            OP_ANDI:  begin use_imm = 1'b1; we = 1'b1; alu_op = ALU_AND; ext = EXT_ZERO; end
            OP_ORI:   begin use_imm = 1'b1; we = 1'b1; alu_op = ALU_OR;  ext = EXT_ZERO; end
            OP_XORI:  begin use_imm = 1'b1; we = 1'b1; alu_op = ALU_XOR; ext = EXT_ZERO; end
            OP_LUI:   begin use_imm = 1'b1; we = 1'b1; alu_op = ALU_LUI; ext = EXT_ZERO; end
            OP_LW:    begin use_imm = 1'b1; we = 1'b1; cs = 1'b1; rd = 1'b1; wb_sel = WB_DM; end
            OP_SW:    begin use_imm = 1'b1; cs = 1'b1; end
            default: ;
        endcase
        imm = (ext == EXT_SIGN) ? {{16{bus.ins[15]}}, bus.ins[15:0]} : {16'h0, bus.ins[15:0]};
        if (use_imm) alu_b = imm;
    end

    exec_alu u_alu (.op(alu_op), .a(alu_a), .b(alu_b), .result(alu_res), .zero(alu_zero));

    assign pc1   = pc_q + 32'd1;
    assign taken = (opcode == OP_BEQ) ? alu_zero : !alu_zero;

    always_comb begin
        case (pc_sel)
            PC_BRANCH: next_pc = taken ? pc1 + {{16{bus.ins[15]}}, bus.ins[15:0]} : pc1;
            PC_JIMM:   next_pc = {16'h0, bus.ins[15:0]};
            PC_JREG:   next_pc = bus.rs_data;
            default:   next_pc = pc1;
        endcase
    end

    // On the halting syscall the PC stays on the syscall itself
    always_ff @(posedge clk) begin
        if (clr) begin
            pc_q      <= RESET_PC;
            halt_q    <= 1'b0;
            display_q <= '0;
        end else if (!halt_q) begin
            if (is_syscall && bus.v0_data == HALT_CODE) begin
                halt_q <= 1'b1;
            end else begin
                pc_q <= next_pc;
                if (is_syscall) display_q <= bus.a0_data;
            end
        end
    end

    assign bus.pc         = pc_q;
    assign bus.halt       = halt_q;
    assign bus.display    = display_q;
    assign bus.rs_num     = bus.ins[25:21];
    assign bus.rt_num     = bus.ins[20:16];
    assign bus.wr_num     = dst;
    assign bus.wr_en      = we && (dst != 5'd0) && !halt_q;
    assign bus.wr_data    = (wb_sel == WB_DM) ? bus.dm_rdata : (wb_sel == WB_PC1) ? pc1 : alu_res;
    assign bus.alu_result = alu_res;
    assign bus.dm_addr    = alu_res[9:2];
    assign bus.dm_wdata   = bus.rt_data;
    assign bus.dm_cs      = cs && !halt_q;
    assign bus.dm_rd      = rd;
endmodule

// File: tb/tb_mips_exec_core.sv
// Randomized bench for mips_exec_core against an instruction-level reference model.
module tb_mips_exec_core;
    logic clk = 1'b0;
    logic clr;
    int n_chk = 0, n_pass = 0;

    mips_exec_core_if bus ();
    mips_exec_core #(.RESET_PC(32'h0), .HALT_CODE(32'd10)) dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        bit alu_v; logic [31:0] alu; logic [4:0] wn; bit we; logic [31:0] wd;
        bit cs; bit rd; logic [31:0] npc; bit sys;
    } exp_t;

    logic [31:0] mpc = 32'h0, mdisp = 32'h0;
    bit          mhalt = 1'b0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (pc model %0d)", tag, got, exp, mpc);
    endtask

    function automatic exp_t ref_model(logic [31:0] i, logic [31:0] p, logic [31:0] rs,
                                       logic [31:0] rt, logic [31:0] dm);
        exp_t e; logic [31:0] se, ze, r; logic [4:0] sh; bit wr_alu;
        se = {{16{i[15]}}, i[15:0]}; ze = {16'h0, i[15:0]}; sh = i[10:6];
        e.alu_v = 0; e.alu = 0; e.wn = i[20:16]; e.we = 0; e.wd = 0;
        e.cs = 0; e.rd = 0; e.npc = p + 1; e.sys = 0; r = 0; wr_alu = 1;
        case (i[31:26])
            6'h00: begin
                e.wn = i[15:11];
                case (i[5:0])
                    6'h20, 6'h21: r = rs + rt;
                    6'h22, 6'h23: r = rs - rt;
                    6'h24: r = rs & rt;
                    6'h25: r = rs | rt;
                    6'h26: r = rs ^ rt;
                    6'h27: r = ~(rs | rt);
                    6'h2A: r = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
                    6'h2B: r = (rs < rt) ? 32'd1 : 32'd0;
                    6'h00: r = rt << sh;
                    6'h02: r = rt >> sh;
                    6'h03: r = $unsigned($signed(rt) >>> sh);
                    6'h04: r = rt << rs[4:0];
                    6'h06: r = rt >> rs[4:0];
                    6'h07: r = $unsigned($signed(rt) >>> rs[4:0]);
                    6'h08: begin wr_alu = 0; e.npc = rs; end
                    6'h0C: begin wr_alu = 0; e.sys = 1; end
                    default: wr_alu = 0;
                endcase
            end
            6'h02: begin wr_alu = 0; e.npc = ze; end
            6'h03: begin wr_alu = 0; e.npc = ze; e.wn = 5'd31; e.we = 1; e.wd = p + 1; end
            6'h04: begin wr_alu = 0; if (rs == rt) e.npc = p + 1 + se; end
            6'h05: begin wr_alu = 0; if (rs != rt) e.npc = p + 1 + se; end
            6'h08, 6'h09: r = rs + se;
            6'h0A: r = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0;
            6'h0B: r = (rs < se) ? 32'd1 : 32'd0;
            6'h0C: r = rs & ze;
            6'h0D: r = rs | ze;
            6'h0E: r = rs ^ ze;
            6'h0F: r = ze * 32'd65536;
            6'h23: begin wr_alu = 0; e.alu_v = 1; e.alu = rs + se; e.cs = 1; e.rd = 1; e.we = 1; e.wd = dm; end
            6'h2B: begin wr_alu = 0; e.alu_v = 1; e.alu = rs + se; e.cs = 1; end
            default: wr_alu = 0;
        endcase
        if (wr_alu) begin e.alu_v = 1; e.alu = r; e.we = 1; e.wd = r; end
        if (e.wn == 5'd0) e.we = 0;
        return e;
    endfunction

    task automatic drive(logic [31:0] i, logic [31:0] rs, logic [31:0] rt,
                         logic [31:0] v0, logic [31:0] a0, logic [31:0] dm);
        bus.ins = i; bus.rs_data = rs; bus.rt_data = rt;
        bus.v0_data = v0; bus.a0_data = a0; bus.dm_rdata = dm;
    endtask

    // One clock: combinational checks at the falling edge, state checks after the rising edge.
    task automatic cycle(bit check_comb = 1'b1);
        exp_t e;
        @(negedge clk);
        e = ref_model(bus.ins, mpc, bus.rs_data, bus.rt_data, bus.dm_rdata);
        if (mhalt) begin e.we = 0; e.cs = 0; end
        if (check_comb) begin
            chk("rs_num", 32'(bus.rs_num), 32'(bus.ins[25:21]));
            chk("rt_num", 32'(bus.rt_num), 32'(bus.ins[20:16]));
            chk("dm_wdata", bus.dm_wdata, bus.rt_data);
            chk("wr_en", 32'(bus.wr_en), 32'(e.we));
            if (e.we) begin
                chk("wr_num", 32'(bus.wr_num), 32'(e.wn));
                chk("wr_data", bus.wr_data, e.wd);
            end
            chk("dm_cs", 32'(bus.dm_cs), 32'(e.cs));
            if (e.cs) begin
                chk("dm_rd", 32'(bus.dm_rd), 32'(e.rd));
                chk("dm_addr", 32'(bus.dm_addr), 32'(e.alu[9:2]));
            end
            if (e.alu_v) chk("alu_result", bus.alu_result, e.alu);
        end
        @(posedge clk);
        if (clr) begin
            mpc = 32'h0; mhalt = 0; mdisp = 32'h0;
        end else if (!mhalt) begin
            if (e.sys && bus.v0_data == 32'd10) mhalt = 1;
            else begin
                mpc = e.npc;
                if (e.sys) mdisp = bus.a0_data;
            end
        end
        #1;
        chk("pc", bus.pc, mpc);
        chk("halt", 32'(bus.halt), 32'(mhalt));
        chk("display", bus.display, mdisp);
    endtask

    logic [5:0] ops[16]    = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                               6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    logic [5:0] functs[20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h0C,
                               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B, 6'h01, 6'h3F};

    initial begin
        logic [31:0] i, v0, frozen;
        // reset with arbitrary instruction on the bus
        clr = 1'b1;
        drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        cycle(1'b0);
        chk("reset_pc", bus.pc, 32'h0);
        chk("reset_halt", 32'(bus.halt), 32'h0);
        chk("reset_display", bus.display, 32'h0);
        clr = 1'b0;
        drive(32'h0, 0, 0, 0, 0, 0);
        cycle();
        chk("pc_after_release", bus.pc, 32'd1);

        drive(32'h2008FFFF, 32'd5, $urandom, 0, 0, 0); #1;
        chk("addi_alu", bus.alu_result, 32'd4);
        chk("addi_wr_num", 32'(bus.wr_num), 32'd8);
        chk("addi_wr_en", 32'(bus.wr_en), 32'd1);
        cycle();
        drive(32'h3409FFFF, 32'd0, $urandom, 0, 0, 0); #1;
        chk("ori_alu", bus.alu_result, 32'h0000FFFF);
        cycle();

        drive(32'h0800000A, 0, 0, 0, 0, 0); cycle();
        drive(32'h1000FFFE, 32'h77, 32'h77, 0, 0, 0); cycle();
        chk("beq_taken_pc", bus.pc, 32'd9);
        drive(32'h0800000A, 0, 0, 0, 0, 0); cycle();
        drive(32'h1000FFFE, 32'h77, 32'h78, 0, 0, 0); cycle();
        chk("beq_not_taken_pc", bus.pc, 32'd11);
        drive(32'h0800000A, 0, 0, 0, 0, 0); cycle();
        drive(32'h1400FFFE, 32'h77, 32'h77, 0, 0, 0); cycle();
        chk("bne_not_taken_pc", bus.pc, 32'd11);
        drive(32'h0800000A, 0, 0, 0, 0, 0); cycle();
        drive(32'h1400FFFE, 32'h77, 32'h78, 0, 0, 0); cycle();
        chk("bne_taken_pc", bus.pc, 32'd9);

        drive(32'h08000003, 0, 0, 0, 0, 0); cycle();
        drive(32'h0C000040, 0, 0, 0, 0, 0); #1;
        chk("jal_wr_num", 32'(bus.wr_num), 32'd31);
        chk("jal_wr_data", bus.wr_data, 32'd4);
        cycle();
        chk("jal_pc", bus.pc, 32'h40);
        drive(32'h00800008, 32'h4, 0, 0, 0, 0); cycle();
        chk("jr_pc", bus.pc, 32'd4);

        drive(32'h8D090004, 32'h10, 32'h1234, 0, 0, 32'hCAFEF00D); #1;
        chk("lw_dm_addr", 32'(bus.dm_addr), 32'd5);
        chk("lw_dm_cs_rd", {30'b0, bus.dm_cs, bus.dm_rd}, 32'd3);
        chk("lw_wr_data", bus.wr_data, 32'hCAFEF00D);
        cycle();
        drive(32'hAD090004, 32'h10, 32'h5678, 0, 0, 32'h1); #1;
        chk("sw_dm_rd", 32'(bus.dm_rd), 32'd0);
        chk("sw_wr_en", 32'(bus.wr_en), 32'd0);
        chk("sw_dm_wdata", bus.dm_wdata, 32'h5678);
        cycle();

        drive(32'h0000000C, 0, 0, 32'd1, 32'hDEAD, 0); cycle();
        chk("syscall_display", bus.display, 32'hDEAD);

        for (int n = 0; n < 400; n++) begin
            i = $urandom;
            i[31:26] = ops[$urandom_range(15)];
            if (i[31:26] == 6'h00) i[5:0] = functs[$urandom_range(19)];
            if ($urandom_range(19) == 0) i[31:26] = 6'h3F;
            v0 = $urandom;
            if (v0 == 32'd10) v0 = 32'd11;
            drive(i, ($urandom_range(3) == 0) ? 32'h0 : $urandom, ($urandom_range(3) == 0) ? 32'h0 : $urandom,
                  v0, $urandom, $urandom);
            cycle();
        end

        drive(32'h0000000C, 0, 0, 32'd10, 32'hBEEF, 0);
        frozen = mpc;
        cycle();
        chk("halt_set", 32'(bus.halt), 32'd1);
        for (int n = 0; n < 5; n++) begin
            drive(32'h2008FFFF ^ {16'h0, 16'($urandom)}, $urandom, $urandom, 32'd1, $urandom, $urandom); #1;
            chk("halt_wr_en", 32'(bus.wr_en), 32'd0);
            cycle();
            chk("halt_pc_frozen", bus.pc, frozen);
        end
        clr = 1'b1;
        drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        cycle();
        chk("clr_pc", bus.pc, 32'h0);
        chk("clr_halt", 32'(bus.halt), 32'd0);
        clr = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
